uart_recv_os: RTL and testbench

// - Next-generation UART receiver: 16x-style oversampled, majority-voted RX front end.
// - Runtime data length from 5 to MAX_DATA_W bits; parity none/even/odd; 1 or 2 stop bits.
// - Per-frame parity, framing and break status.
// - Sits between the RX pad and the UART register/FIFO layer; replaces the fixed-width receiver.

---
 rtl/uart_recv_os.sv | 213 +++++++++++++++++++++
 tb/tb_uart_recv_os.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/uart_recv_os.sv
// Oversampled UART receiver: majority-voted bits, runtime length/parity/stop config, per-frame error flags.
// Latency: SYNC_STAGES clk plus frame time to recv; no backpressure, recv is a one-cycle strobe.
module uart_recv_os #(
  parameter int MAX_DATA_W  = 9,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  active,
  input  logic                  rx,
  input  logic                  os_tick,
  input  logic [3:0]            data_bits,
  input  logic [1:0]            parity_type,
  input  logic                  stop_type,
  output logic [MAX_DATA_W-1:0] data,
  output logic                  recv,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  break_det,
  output logic                  busy
);

  localparam int CW = $clog2(OVERSAMPLE) + 1;
  localparam logic [CW-1:0] T_ONE = CW'(1);
  localparam logic [CW-1:0] T_LO  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] T_MID = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] T_HI  = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0] T_END = CW'(OVERSAMPLE);
  localparam logic [3:0]    MAXW  = 4'(MAX_DATA_W);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_WAIT  = 3'd5;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [2:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d, cnt_n;
  logic [3:0]             idx_q, idx_d;
  logic [3:0]             n_q, n_d;
  logic [1:0]             par_q, par_d;
  logic                   stop2_q, stop2_d;
  logic                   stop_idx_q, stop_idx_d;
  logic [1:0]             v_q, v_d;
  logic                   bit_q, bit_d;
  logic [MAX_DATA_W-1:0]  sh_q, sh_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   zero_q, zero_d;
  logic [MAX_DATA_W-1:0]  data_q, data_d;
  logic                   recv_q, recv_d;
  logic                   perr_o_q, perr_o_d;
  logic                   ferr_o_q, ferr_o_d;
  logic                   brk_q, brk_d;

  logic rx_s, vote, tick_end, par_en;

  assign rx_s     = sync_q[SYNC_STAGES-1];
  assign cnt_n    = cnt_q + T_ONE;
  assign tick_end = (cnt_n == T_END);
  assign vote     = (v_q[1] & v_q[0]) | (v_q[1] & rx_s) | (v_q[0] & rx_s);
  assign par_en   = (par_q == 2'b01) || (par_q == 2'b10);
  assign sync_d   = {sync_q[SYNC_STAGES-2:0], rx};

  always_comb begin
    prev_d     = prev_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    n_d        = n_q;
    par_d      = par_q;
    stop2_d    = stop2_q;
    stop_idx_d = stop_idx_q;
    v_d        = v_q;
    bit_d      = bit_q;
    sh_d       = sh_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    zero_d     = zero_q;
    data_d     = data_q;
    recv_d     = 1'b0;
    perr_o_d   = perr_o_q;
    ferr_o_d   = ferr_o_q;
    brk_d      = brk_q;
    if (os_tick) begin
      prev_d = rx_s;
      // The counter wraps at the end of each bit, so tick OVERSAMPLE doubles as tick 0 of the next bit.
      if (state_q != S_IDLE && state_q != S_WAIT) begin
        cnt_d = tick_end ? '0 : cnt_n;
        if (cnt_n == T_LO)  v_d[1] = rx_s;
        if (cnt_n == T_MID) v_d[0] = rx_s;
        if (cnt_n == T_HI)  bit_d  = vote;
      end
      case (state_q)
        S_IDLE: begin
          if (prev_q && !rx_s) begin
            state_d    = S_START;
            cnt_d      = '0;
            idx_d      = 4'd0;
            stop_idx_d = 1'b0;
            sh_d       = '0;
            perr_d     = 1'b0;
            ferr_d     = 1'b0;
            zero_d     = 1'b1;
            par_d      = parity_type;
            stop2_d    = stop_type;
            n_d        = (data_bits < 4'd5) ? 4'd5 : ((data_bits > MAXW) ? MAXW : data_bits);
          end
        end
        S_START: begin
          if (cnt_n == T_HI) state_d = vote ? S_IDLE : S_DATA;
        end
        S_DATA: begin
          // idx 0 marks the end of the start bit; data bit k lands at idx k+1.
          if (tick_end) begin
            if (idx_q != 4'd0) sh_d[idx_q - 4'd1] = bit_q;
            idx_d = idx_q + 4'd1;
            if (idx_q == n_q) state_d = par_en ? S_PAR : S_STOP;
          end
        end
        S_PAR: begin
          if (cnt_n == T_HI) begin
            perr_d = vote ^ (^sh_q) ^ (par_q == 2'b10);
            zero_d = zero_q & ~vote;
          end
          if (tick_end) state_d = S_STOP;
        end
        S_STOP: begin
          if (cnt_n == T_HI) begin
            if (stop_idx_q == stop2_q) begin
              recv_d   = 1'b1;
              data_d   = sh_q;
              perr_o_d = perr_q;
              ferr_o_d = ferr_q | ~vote;
              brk_d    = zero_q & ~vote & (sh_q == '0);
              state_d  = vote ? S_IDLE : S_WAIT;
            end else begin
              ferr_d = ferr_q | ~vote;
              zero_d = zero_q & ~vote;
            end
          end
          if (tick_end) stop_idx_d = 1'b1;
        end
        S_WAIT: begin
          if (rx_s) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n || !active) begin
      sync_q     <= '1;
      prev_q     <= 1'b1;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= 4'd0;
      n_q        <= 4'd0;
      par_q      <= 2'b00;
      stop2_q    <= 1'b0;
      stop_idx_q <= 1'b0;
      v_q        <= 2'b00;
      bit_q      <= 1'b0;
      sh_q       <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      zero_q     <= 1'b0;
      recv_q     <= 1'b0;
      perr_o_q   <= 1'b0;
      ferr_o_q   <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      n_q        <= n_d;
      par_q      <= par_d;
      stop2_q    <= stop2_d;
      stop_idx_q <= stop_idx_d;
      v_q        <= v_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      zero_q     <= zero_d;
      recv_q     <= recv_d;
      perr_o_q   <= perr_o_d;
      ferr_o_q   <= ferr_o_d;
      brk_q      <= brk_d;
    end
  end

  // Disabling the receiver keeps the last frame's data visible.
  always_ff @(posedge clk) begin
    if (!arst_n)     data_q <= '0;
    else if (active) data_q <= data_d;
  end

  assign data       = data_q;
  assign recv       = recv_q;
  assign parity_err = perr_o_q;
  assign frame_err  = ferr_o_q;
  assign break_det  = brk_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_recv_os.sv
// Directed bench for uart_recv_os: OVERSAMPLE=16, os_tick always high, one bit = 16 clk.
module tb_uart_recv_os;

  logic       clk = 1'b0;
  logic       arst_n, active, rx, os_tick, stop_type;
  logic [3:0] data_bits;
  logic [1:0] parity_type;
  logic [8:0] data;
  logic       recv, parity_err, frame_err, break_det, busy;

  int checks = 0;
  int failures = 0;
  int recv_cnt = 0;
  int r0;
  logic [8:0] cap_data = '0;
  logic       cap_pe = 1'b0, cap_fe = 1'b0, cap_brk = 1'b0;

  uart_recv_os #(.MAX_DATA_W(9), .OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .arst_n(arst_n), .active(active), .rx(rx), .os_tick(os_tick),
    .data_bits(data_bits), .parity_type(parity_type), .stop_type(stop_type),
    .data(data), .recv(recv), .parity_err(parity_err), .frame_err(frame_err),
    .break_det(break_det), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (recv) begin
      recv_cnt = recv_cnt + 1;
      cap_data = data;
      cap_pe   = parity_err;
      cap_fe   = frame_err;
      cap_brk  = break_det;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input logic spike);
    for (int i = 0; i < 16; i++) begin
      rx = (spike && i == 8) ? ~b : b;
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [8:0] val, input int nb, input logic [1:0] pt,
                            input logic two_stop, input logic flip_par, input logic stop_val,
                            input int spike_bit);
    logic p;
    p = 1'b0;
    send_bit(1'b0, 1'b0);
    for (int k = 0; k < nb; k++) begin
      send_bit(val[k], k == spike_bit);
      p = p ^ val[k];
    end
    if (pt == 2'b01 || pt == 2'b10) send_bit(p ^ (pt == 2'b10) ^ flip_par, 1'b0);
    send_bit(stop_val, 1'b0);
    if (two_stop) send_bit(stop_val, 1'b0);
    rx = 1'b1;
    idle(32);
  endtask

  initial begin
    int busy_cycles;
    arst_n = 1'b0; active = 1'b1; rx = 1'b1; os_tick = 1'b1;
    data_bits = 4'd8; parity_type = 2'b00; stop_type = 1'b0;
    idle(3);
    check("rst_data", data, 0);
    check("rst_recv", recv, 0);
    check("rst_busy", busy, 0);
    check("rst_flags", {parity_err, frame_err, break_det}, 0);
    arst_n = 1'b1;
    idle(20);

    // 8N1 0xA5
    r0 = recv_cnt;
    send_frame(9'h0A5, 8, 2'b00, 1'b0, 1'b0, 1'b1, -1);
    check("t1_count", recv_cnt - r0, 1);
    check("t1_data", cap_data, 9'h0A5);
    check("t1_flags", {cap_pe, cap_fe, cap_brk}, 0);
    check("t1_busy", busy, 0);

    // 9 bits, odd parity, 2 stop bits
    data_bits = 4'd9; parity_type = 2'b10; stop_type = 1'b1;
    r0 = recv_cnt;
    send_frame(9'h1C3, 9, 2'b10, 1'b1, 1'b0, 1'b1, -1);
    check("t2_count", recv_cnt - r0, 1);
    check("t2_data", cap_data, 9'h1C3);
    check("t2_flags", {cap_pe, cap_fe, cap_brk}, 0);
    send_frame(9'h1C3, 9, 2'b10, 1'b1, 1'b1, 1'b1, -1);
    check("t2_count_flip", recv_cnt - r0, 2);
    check("t2_perr", {cap_pe, cap_fe, cap_brk}, 3'b100);
    check("t2_perr_hold", parity_err, 1);

    // stop bit sampled 0
    data_bits = 4'd8; parity_type = 2'b00; stop_type = 1'b0;
    r0 = recv_cnt;
    send_frame(9'h055, 8, 2'b00, 1'b0, 1'b0, 1'b0, -1);
    check("t3_count", recv_cnt - r0, 1);
    check("t3_data", cap_data, 9'h055);
    check("t3_ferr", {cap_pe, cap_fe, cap_brk}, 3'b010);

    // held break: 40 bit times low
    r0 = recv_cnt;
    rx = 1'b0;
    idle(640);
    check("brk_count", recv_cnt - r0, 1);
    check("brk_flags", {cap_pe, cap_fe, cap_brk}, 3'b011);
    check("brk_data", cap_data, 0);
    check("brk_busy_low", busy, 1);
    rx = 1'b1;
    idle(20);
    check("brk_busy_rel", busy, 0);
    check("brk_count_rel", recv_cnt - r0, 1);

    // 4-clk glitch on idle line
    r0 = recv_cnt;
    busy_cycles = 0;
    rx = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i == 4) rx = 1'b1;
      @(negedge clk);
      if (busy) busy_cycles++;
    end
    check("glitch_busy_seen", (busy_cycles > 0), 1);
    check("glitch_busy_short", (busy_cycles <= 10), 1);
    check("glitch_busy_end", busy, 0);
    check("glitch_count", recv_cnt - r0, 0);

    // single-tick spike on a vote point of data bit 3
    r0 = recv_cnt;
    send_frame(9'h096, 8, 2'b00, 1'b0, 1'b0, 1'b1, 3);
    check("spike_count", recv_cnt - r0, 1);
    check("spike_data", cap_data, 9'h096);

    // reset during bit 3 of 0xA5
    r0 = recv_cnt;
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    rx = 1'b0;
    idle(5);
    arst_n = 1'b0; rx = 1'b1;
    @(negedge clk);
    check("mrst_data", data, 0);
    check("mrst_recv_busy", {recv, busy}, 0);
    check("mrst_flags", {parity_err, frame_err, break_det}, 0);
    arst_n = 1'b1;
    idle(32);
    check("mrst_count", recv_cnt - r0, 0);
    send_frame(9'h03C, 8, 2'b00, 1'b0, 1'b0, 1'b1, -1);
    check("mrst_next_count", recv_cnt - r0, 1);
    check("mrst_next_data", cap_data, 9'h03C);

    // active dropped mid-frame
    r0 = recv_cnt;
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    active = 1'b0; rx = 1'b1;
    idle(2);
    check("act_busy", busy, 0);
    check("act_data_hold", data, 9'h03C);
    active = 1'b1;
    idle(32);
    check("act_count", recv_cnt - r0, 0);

    // data_bits below 5 act as 5
    data_bits = 4'd2;
    send_frame(9'h015, 5, 2'b00, 1'b0, 1'b0, 1'b1, -1);
    check("len5_count", recv_cnt - r0, 1);
    check("len5_data", data, 9'h015);
    check("len5_flags", {parity_err, frame_err, break_det}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
